piso_frame_serializer: RTL and testbench

//  Parametrised multi-channel parallel-in/serial-out serializer: accepts a frame of NUM_CH words
//  of DATA_W bits (e.g. spectrogram bins) over a valid/ready handshake and shifts it out one bit
//  per enabled clock with valid/first/last framing. A one-frame holding buffer lets the next frame

---
 rtl/piso_pkg.sv | 31 +++
 rtl/piso_shift_core.sv | 59 +++++
 rtl/piso_frame_serializer.sv | 181 ++++++++++++++++++
 tb/tb_piso_frame_serializer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared types and sizing helpers for the frame serializer.
//   state_e    : serializer FSM encoding (IDLE = 1'b0, SHIFT = 1'b1)
//   frame_w()  : frame length in bits (NUM_CH * DATA_W)
//   cnt_w()    : counter width for a 0..n-1 counter, never below 1 bit
//   FRAME_W / BIT_CNT_W / CH_CNT_W : sizes for the default configuration
// -----------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int frame_w(input int data_w, input int num_ch);
    return data_w * num_ch;
  endfunction

  // A single-value counter still needs one bit to be a legal vector.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_DATA_W = 12;
  localparam int DEF_NUM_CH = 4;
  localparam int FRAME_W    = frame_w(DEF_DATA_W, DEF_NUM_CH);
  localparam int BIT_CNT_W  = cnt_w(DEF_DATA_W);
  localparam int CH_CNT_W   = cnt_w(DEF_NUM_CH);

endpackage

// File: rtl/piso_shift_core.sv
// -----------------------------------------------------------------------------
// piso_shift_core
// Frame-wide shift register. On load it captures a whole frame, reordering each
// word so that the bit to be sent first always sits at the low end; every shift
// then moves the register one place towards bit 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture load_data_i (wins over shift_i)
//   load_data_i: frame, channel c at [c*DATA_W +: DATA_W]
//   shift_i    : advance one bit
//   bit_o      : bit currently at the head of the register
// -----------------------------------------------------------------------------
module piso_shift_core #(
  parameter int DATA_W    = 12,
  parameter int NUM_CH    = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic [DATA_W*NUM_CH-1:0] load_data_i,
  input  logic                     shift_i,
  output logic                     bit_o
);

  localparam int FW = DATA_W * NUM_CH;

  logic [FW-1:0] load_order;
  logic [FW-1:0] sreg_q, sreg_d;

  // MSB-first output is obtained by mirroring each word at load time, so the
  // shift direction never changes.
  always_comb begin
    load_order = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < DATA_W; b++) begin
        if (MSB_FIRST) load_order[c*DATA_W + b] = load_data_i[c*DATA_W + DATA_W - 1 - b];
        else           load_order[c*DATA_W + b] = load_data_i[c*DATA_W + b];
      end
    end
  end

  // NOTE: sreg_d gets its hold value first, so every path assigns it and no
  // latch can be inferred.
  always_comb begin
    sreg_d = sreg_q;
    if (load_i)       sreg_d = load_order;
    else if (shift_i) sreg_d = sreg_q >> 1;
  end

  // NOTE: state updates use <= so every flop samples pre-edge values,
  // independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sreg_q <= '0;
    else        sreg_q <= sreg_d;
  end

  assign bit_o = sreg_q[0];

endmodule

// File: rtl/piso_frame_serializer.sv
// -----------------------------------------------------------------------------
// piso_frame_serializer
// Parallel-in / serial-out frame serializer with a one-frame holding buffer so
// consecutive frames stream without a gap.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : frame, channel c at [c*DATA_W +: DATA_W]
//   in_valid   : frame offered; transfer when in_valid & in_ready
//   in_ready   : holding buffer empty
//   ser_en     : shift enable; low freezes FSM, counters and serial outputs
//   ser_out    : serial bit (registered)
//   ser_valid  : ser_out carries a frame bit
//   ser_first  : first bit of a frame
//   ser_last   : last bit of a frame
//   ser_ch     : channel index of the current bit
//   busy       : a frame is held in the shift register or the buffer
// -----------------------------------------------------------------------------
module piso_frame_serializer
  import piso_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int NUM_CH    = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       ser_en,
  output logic                       ser_out,
  output logic                       ser_valid,
  output logic                       ser_first,
  output logic                       ser_last,
  output logic [cnt_w(NUM_CH)-1:0]   ser_ch,
  output logic                       busy
);

  localparam int FW        = frame_w(DATA_W, NUM_CH);
  localparam int BIT_CW    = cnt_w(DATA_W);
  localparam int CH_CW     = cnt_w(NUM_CH);
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_W - 1);
  localparam logic [CH_CW-1:0]  CH_LAST  = CH_CW'(NUM_CH - 1);

  state_e              state_q, state_d;
  logic                buf_full_q, buf_full_d;
  logic [FW-1:0]       buf_data_q, buf_data_d;
  logic [BIT_CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CH_CW-1:0]    ch_cnt_q, ch_cnt_d;
  logic                ser_out_q, ser_out_d;
  logic                ser_valid_q, ser_valid_d;
  logic                ser_first_q, ser_first_d;
  logic                ser_last_q, ser_last_d;
  logic [CH_CW-1:0]    ser_ch_q, ser_ch_d;

  logic core_load, core_shift, core_bit;
  logic bit_last, frame_last;

  assign bit_last   = (bit_cnt_q == BIT_LAST);
  assign frame_last = bit_last && (ch_cnt_q == CH_LAST);

  piso_shift_core #(
    .DATA_W    (DATA_W),
    .NUM_CH    (NUM_CH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (core_load),
    .load_data_i (buf_data_q),
    .shift_i     (core_shift),
    .bit_o       (core_bit)
  );

  always_comb begin
    state_d     = state_q;
    buf_full_d  = buf_full_q;
    buf_data_d  = buf_data_q;
    bit_cnt_d   = bit_cnt_q;
    ch_cnt_d    = ch_cnt_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    ser_first_d = ser_first_q;
    ser_last_d  = ser_last_q;
    ser_ch_d    = ser_ch_q;
    core_load   = 1'b0;
    core_shift  = 1'b0;

    // Accept only into an empty buffer; a drain below requires a full one, so
    // the two never happen on the same edge.
    if (in_valid && !buf_full_q) begin
      buf_data_d = in_data;
      buf_full_d = 1'b1;
    end

    if (ser_en) begin
      case (state_q)
        IDLE: begin
          ser_out_d   = 1'b0;
          ser_valid_d = 1'b0;
          ser_first_d = 1'b0;
          ser_last_d  = 1'b0;
          ser_ch_d    = '0;
          if (buf_full_q) begin
            core_load  = 1'b1;
            buf_full_d = 1'b0;
            bit_cnt_d  = '0;
            ch_cnt_d   = '0;
            state_d    = SHIFT;
          end
        end

        SHIFT: begin
          // The head of the shift register moves into the output register.
          core_shift  = 1'b1;
          ser_out_d   = core_bit;
          ser_valid_d = 1'b1;
          ser_first_d = (bit_cnt_q == '0) && (ch_cnt_q == '0);
          ser_last_d  = frame_last;
          ser_ch_d    = ch_cnt_q;

          if (bit_last) begin
            bit_cnt_d = '0;
            ch_cnt_d  = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end

          // Reloading on the edge that emits the last bit puts the next
          // frame's first bit on the very next edge.
          if (frame_last) begin
            if (buf_full_q) begin
              core_load  = 1'b1;
              buf_full_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the buffer data is cleared on reset along with its flag, so a
  // discarded frame leaves no trace in the register after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_full_q  <= 1'b0;
      buf_data_q  <= '0;
      bit_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      ser_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      buf_full_q  <= buf_full_d;
      buf_data_q  <= buf_data_d;
      bit_cnt_q   <= bit_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
      ser_ch_q    <= ser_ch_d;
    end
  end

  assign in_ready  = !buf_full_q;
  assign busy      = buf_full_q || (state_q == SHIFT);
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;
  assign ser_ch    = ser_ch_q;

endmodule

// File: tb/tb_piso_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_frame_serializer
// Three serializer instances: A (12x2, LSB first) and B (12x2, MSB first) share
// one input stream; C (1x1) covers the single-bit frame. Expected bits come
// from a model that indexes the frame word by word.
// -----------------------------------------------------------------------------
module tb_piso_frame_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] in_data;
  logic        in_valid;
  logic        ser_en;

  logic       a_in_ready, a_ser_out, a_ser_valid, a_ser_first, a_ser_last, a_busy;
  logic [0:0] a_ser_ch;
  logic       b_in_ready, b_ser_out, b_ser_valid, b_ser_first, b_ser_last, b_busy;
  logic [0:0] b_ser_ch;

  logic [0:0] c_in_data;
  logic       c_in_valid;
  logic       c_in_ready, c_ser_out, c_ser_valid, c_ser_first, c_ser_last, c_busy;
  logic [0:0] c_ser_ch;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_frame_serializer #(.DATA_W(12), .NUM_CH(2), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
    .ser_en(ser_en), .ser_out(a_ser_out), .ser_valid(a_ser_valid), .ser_first(a_ser_first),
    .ser_last(a_ser_last), .ser_ch(a_ser_ch), .busy(a_busy));

  piso_frame_serializer #(.DATA_W(12), .NUM_CH(2), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
    .ser_en(ser_en), .ser_out(b_ser_out), .ser_valid(b_ser_valid), .ser_first(b_ser_first),
    .ser_last(b_ser_last), .ser_ch(b_ser_ch), .busy(b_busy));

  piso_frame_serializer #(.DATA_W(1), .NUM_CH(1), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .ser_en(ser_en), .ser_out(c_ser_out), .ser_valid(c_ser_valid), .ser_first(c_ser_first),
    .ser_last(c_ser_last), .ser_ch(c_ser_ch), .busy(c_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit k of a 2x12 frame: channel k/12, position k%12 counted from the end
  // that is sent first.
  function automatic logic model_bit(input logic [23:0] f, input int k, input bit msb);
    int c;
    int i;
    int idx;
    c   = k / 12;
    i   = k % 12;
    idx = msb ? (11 - i) : i;
    return f[c*12 + idx];
  endfunction

  task automatic check_bit(input string tag, input logic [23:0] f, input int k);
    logic [9:0] got;
    logic [9:0] exp;
    logic       ch;
    ch  = (k >= 12);
    exp = {1'b1, 1'b1, k == 0, k == 0, k == 23, k == 23, ch, ch,
           model_bit(f, k, 1'b0), model_bit(f, k, 1'b1)};
    got = {a_ser_valid, b_ser_valid, a_ser_first, b_ser_first, a_ser_last, b_ser_last,
           a_ser_ch, b_ser_ch, a_ser_out, b_ser_out};
    check($sformatf("%s_bit%0d", tag, k), 32'(got), 32'(exp));
    if (k < 23) check($sformatf("%s_busy%0d", tag, k), 32'(a_busy), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    logic [9:0] got;
    got = {a_ser_valid, a_ser_out, a_ser_first, a_ser_last, a_ser_ch,
           b_ser_valid, b_ser_out, b_ser_first, b_ser_last, b_ser_ch};
    check(tag, 32'(got), 32'd0);
  endtask

  // Assumes the first bit of f is on the outputs now. Optionally stalls at
  // bit stall_at and offers f_next on the first stall cycle.
  task automatic expect_frame(input string tag, input logic [23:0] f, input int stall_at,
                              input int stall_len, input bit offer, input logic [23:0] f_next);
    for (int k = 0; k < 24; k++) begin
      check_bit(tag, f, k);
      if (k == stall_at) begin
        ser_en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          if (offer && s == 0) begin
            in_valid = 1'b1;
            in_data  = f_next;
          end
          tick();
          if (offer && s == 0) begin
            in_valid = 1'b0;
            in_data  = 24'($urandom);
            check({tag, "_stall_rdy"}, 32'(a_in_ready), 32'd0);
          end
          check_bit({tag, "_stall"}, f, k);
        end
        ser_en = 1'b1;
      end
      tick();
    end
  endtask

  task automatic run_single(input string tag, input logic [23:0] f, input int stall_at,
                            input int stall_len, input bit offer, input logic [23:0] f_next);
    check({tag, "_rdy_pre"}, 32'(a_in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = f;
    tick();
    in_valid = 1'b0;
    in_data  = 24'($urandom);
    check({tag, "_rdy_full"}, 32'(a_in_ready), 32'd0);
    check({tag, "_busy_buf"}, 32'(a_busy), 32'd1);
    check_idle({tag, "_lat1"});
    tick();
    check_idle({tag, "_lat2"});
    check({tag, "_rdy_drained"}, 32'(a_in_ready), 32'd1);
    tick();
    expect_frame(tag, f, stall_at, stall_len, offer, f_next);
    if (offer) expect_frame({tag, "_next"}, f_next, -1, 0, 1'b0, 24'd0);
    check_idle({tag, "_end"});
    check({tag, "_busy_end"}, 32'(a_busy), 32'd0);
  endtask

  // Leaves F1 on its first bit with F2 sitting in the holding buffer.
  task automatic start_pair(input string tag, input logic [23:0] f1, input logic [23:0] f2);
    in_valid = 1'b1;
    in_data  = f1;
    tick();
    in_data = f2;
    check({tag, "_rdy_full"}, 32'(a_in_ready), 32'd0);
    tick();
    check({tag, "_rdy_drained"}, 32'(a_in_ready), 32'd1);
    check_idle({tag, "_lat"});
    tick();
    in_valid = 1'b0;
    in_data  = 24'($urandom);
    check({tag, "_rdy_full2"}, 32'(a_in_ready), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] f1, f2;
    int          vcount;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    ser_en     = 1'b1;
    c_in_valid = 1'b0;
    c_in_data  = '0;

    // Reset state.
    #12;
    check_idle("rst_hold");
    #11 rst_n = 1'b1;
    tick();
    check_idle("rst_idle");
    check("rst_ready", 32'({a_in_ready, b_in_ready, c_in_ready}), 32'h7);
    check("rst_busy", 32'({a_busy, b_busy, c_busy}), 32'd0);

    // Reference frame, both bit orders.
    run_single("spec", {12'h3F1, 12'hA5C}, -1, 0, 1'b0, 24'd0);

    // Back-to-back frames with in_valid held.
    f1 = 24'($urandom);
    f2 = 24'($urandom);
    start_pair("b2b", f1, f2);
    expect_frame("b2b_f1", f1, -1, 0, 1'b0, 24'd0);
    expect_frame("b2b_f2", f2, -1, 0, 1'b0, 24'd0);
    check_idle("b2b_end");

    // Stall at bit 7 for 5 cycles, with a frame accepted during the stall.
    run_single("stall", {12'h3F1, 12'hA5C}, 7, 5, 1'b1, 24'($urandom));

    // Randomised frames, stall points and buffered follow-on frames.
    for (int r = 0; r < 6; r++) begin
      int sa;
      sa = int'($urandom_range(0, 24)) - 1;
      run_single($sformatf("rnd%0d", r), 24'($urandom), sa, int'($urandom_range(1, 4)),
                 (sa >= 0) && $urandom_range(0, 1) == 1, 24'($urandom));
    end

    // Asynchronous reset at bit 10 with the buffer full.
    f1 = 24'($urandom);
    f2 = 24'($urandom);
    start_pair("rst", f1, f2);
    for (int k = 0; k < 10; k++) begin
      check_bit("rst", f1, k);
      tick();
    end
    check_bit("rst", f1, 10);
    #2 rst_n = 1'b0;
    #1;
    check_idle("rst_async_out");
    check("rst_async_busy", 32'(a_busy), 32'd0);
    tick();
    tick();
    #3 rst_n = 1'b1;
    tick();
    check("rst_rel_ready", 32'(a_in_ready), 32'd1);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_ser_valid || b_ser_valid) vcount++;
      tick();
    end
    check("rst_no_valid", 32'(vcount), 32'd0);
    run_single("rst_recover", 24'($urandom), -1, 0, 1'b0, 24'd0);

    // Single-bit frames on the 1x1 instance.
    for (int v = 1; v >= 0; v--) begin
      check("c_rdy_pre", 32'(c_in_ready), 32'd1);
      c_in_valid = 1'b1;
      c_in_data  = 1'(v);
      tick();
      c_in_valid = 1'b0;
      c_in_data  = 1'(~v);
      check("c_rdy_full", 32'(c_in_ready), 32'd0);
      tick();
      check("c_lat", 32'({c_ser_valid, c_ser_out}), 32'd0);
      tick();
      check($sformatf("c_bit_v%0d", v),
            32'({c_ser_valid, c_ser_first, c_ser_last, c_ser_ch, c_ser_out}),
            32'({1'b1, 1'b1, 1'b1, 1'b0, 1'(v)}));
      tick();
      check("c_end", 32'({c_ser_valid, c_ser_out, c_ser_first, c_ser_last, c_busy}), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
